// File: rtl/iecdrv_debounce.sv
// iecdrv_debounce
//   Multi-channel input conditioner for the IEC drive. Each channel passes
//   through a two-flop synchroniser and then a stability filter: o_out only
//   takes a new level after the synchronised input has differed from it for
//   STABLE consecutive clocks. Optional registered edge pulses.
//
// Parameters
//   WIDTH  - number of independent channels
//   STABLE - consecutive differing clocks required before o_out updates (1..65535)
//   INIT   - reset value of the synchroniser stages and o_out, per bit
//
// Ports
//   i_clk      - clock, all state changes on the rising edge
//   i_reset    - synchronous active-high reset
//   i_in       - asynchronous channel inputs
//   o_out      - filtered, synchronised levels
//   o_rise     - one-cycle pulse per channel when o_out goes 0->1
//   o_fall     - one-cycle pulse per channel when o_out goes 1->0
//   o_changed  - OR of all o_rise and o_fall bits
//
// Build option
//   IECDRV_DEBOUNCE_EDGE_EN - when defined, the rise/fall/changed registers
//   are built; otherwise those outputs are tied to 0.

module iecdrv_debounce #(
  parameter int               WIDTH  = 1,
  parameter int               STABLE = 2,
  parameter logic [WIDTH-1:0] INIT   = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_out,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_changed
);

  localparam int            CW   = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam logic [CW-1:0] TERM = CW'(STABLE - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_out;
  logic [CW-1:0]    r_cnt [WIDTH];

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_upd;

  // A channel updates on the edge where it still differs and its count has
  // already reached STABLE-1; the count therefore never exceeds TERM.
  always_comb begin
    w_diff = r_s2 ^ r_out;
    w_upd  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_upd[i] = w_diff[i] && (r_cnt[i] == TERM);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1  <= INIT;
      r_s2  <= INIT;
      r_out <= INIT;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1  <= i_in;
      r_s2  <= r_s1;
      r_out <= (r_out & ~w_upd) | (r_s2 & w_upd);
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_diff[i] || w_upd[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign o_out = r_out;

`ifdef IECDRV_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;

  // Registered alongside r_out so a pulse lands in the cycle the new level
  // first appears on o_out.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_rise    <= w_upd & r_s2;
      r_fall    <= w_upd & ~r_s2;
      r_changed <= |w_upd;
    end
  end

  assign o_rise    = r_rise;
  assign o_fall    = r_fall;
  assign o_changed = r_changed;
`else
  assign o_rise    = '0;
  assign o_fall    = '0;
  assign o_changed = 1'b0;
`endif

endmodule
